// File: rtl/mem_access_unit_if.sv
//============================================================================
// Module      : mem_access_unit_if
// Description : Data-side SRAM-like bus between the memory-stage load/store
//               engine (master) and the data memory / cache (slave).
//               req/addr_ok is the address handshake; data_ok marks the
//               read response or write completion.
// Ports       : data_req, data_wr, data_size, data_addr, data_wdata (m->s)
//               data_addr_ok, data_data_ok, data_rdata              (s->m)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
//============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store engine. Decodes the M-stage
//               instruction, checks address alignment, issues one bus
//               transaction per valid access, stalls the pipeline while it
//               is outstanding, replicates store data across byte lanes and
//               sign/zero-extends load data.
// Ports       : clk, rst (async, active-low)
//               mem_readM, mem_writeM, instrM, aluoutM, rt_valueM  - M stage
//               excM, flushM, stall_otherM                         - control
//               dbus (mem_access_unit_if.master)                   - data bus
//               mem_rdataM, mem_stallM, adelM, adesM               - results
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              mem_readM,
    input  wire logic              mem_writeM,
    input  wire logic [31:0]       instrM,
    input  wire logic [ADDR_W-1:0] aluoutM,
    input  wire logic [DATA_W-1:0] rt_valueM,
    input  wire logic              excM,
    input  wire logic              flushM,
    input  wire logic              stall_otherM,
    mem_access_unit_if.master      dbus,
    output logic [DATA_W-1:0]      mem_rdataM,
    output logic                   mem_stallM,
    output logic                   adelM,
    output logic                   adesM
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic       is_byte;
    logic       is_half;
    logic       is_word;
    logic       is_signed;
    logic       misaligned;
    logic       acc_valid;
    logic [1:0] dec_size;

    // Only the opcode field matters here; the rest of instrM is ignored.
    logic unused_instr;
    assign unused_instr = ^instrM[25:0];

    assign opcode    = instrM[31:26];
    assign is_byte   = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
    assign is_half   = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
    assign is_word   = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_signed = (opcode == OP_LB) || (opcode == OP_LH);

    // Unrecognised opcodes fall back to a word-sized access without an
    // alignment check; the decoder upstream should never produce them.
    assign dec_size  = is_byte ? SIZE_BYTE : (is_half ? SIZE_HALF : SIZE_WORD);

    assign misaligned = (is_half & aluoutM[0]) | (is_word & (aluoutM[1:0] != 2'b00));
    assign adelM      = mem_readM  & misaligned;
    assign adesM      = mem_writeM & misaligned;
    assign acc_valid  = (mem_readM | mem_writeM) & ~misaligned & ~excM & ~flushM;

    // ------------------------------------------------------------------
    // Load extraction: pick lane by address offset, then extend.
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_extend(
        input logic [31:0] raw,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        case (size)
            SIZE_BYTE: res = {{24{sgn & b[7]}}, b};
            SIZE_HALF: res = {{16{sgn & h[15]}}, h};
            default:   res = raw;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic              discard_q,   discard_d;
    logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
    logic              wr_q,        wr_d;
    logic [1:0]        size_q,      size_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              sign_q,      sign_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            discard_q   <= 1'b0;
            rdata_buf_q <= '0;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            rdata_buf_q <= rdata_buf_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sign_q      <= sign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    logic [31:0] ext_live;
    logic [31:0] ext_buf;

    // Extension uses the captured size/offset/sign so the result does not
    // depend on the M-stage inputs staying put during the response.
    assign ext_live = load_extend(dbus.data_rdata, size_q, addr_q[1:0], sign_q);
    assign ext_buf  = load_extend(rdata_buf_q,     size_q, addr_q[1:0], sign_q);

    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        rdata_buf_d = rdata_buf_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sign_d      = sign_q;
        mem_stallM  = discard_q;
        mem_rdataM  = '0;

        case (state_q)
            ST_IDLE: begin
                if (acc_valid) begin
                    state_d = ST_REQ;
                    wr_d    = mem_writeM;
                    size_d  = dec_size;
                    addr_d  = aluoutM;
                    sign_d  = is_signed;
                    case (dec_size)
                        SIZE_BYTE: wdata_d = {4{rt_valueM[7:0]}};
                        SIZE_HALF: wdata_d = {2{rt_valueM[15:0]}};
                        default:   wdata_d = rt_valueM;
                    endcase
                    mem_stallM = 1'b1;
                end
            end

            ST_REQ: begin
                // The request cannot be withdrawn once raised; a flush only
                // marks the eventual response for disposal.
                mem_stallM = 1'b1;
                if (flushM) begin
                    discard_d = 1'b1;
                end
                if (dbus.data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (dbus.data_data_ok) begin
                    rdata_buf_d = dbus.data_rdata;
                    if (discard_q || flushM) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                    end else if (stall_otherM) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if (!discard_q) begin
                        mem_rdataM = ext_live;
                    end
                end else begin
                    mem_stallM = 1'b1;
                    if (flushM) begin
                        discard_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                // Instruction is still in M because of another stall source;
                // keep presenting the captured load result, never reissue.
                mem_rdataM = ext_buf;
                if (!stall_otherM || flushM) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbus.data_req   = (state_q == ST_REQ);
    assign dbus.data_wr    = wr_q;
    assign dbus.data_size  = size_q;
    assign dbus.data_addr  = addr_q;
    assign dbus.data_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit. Inputs
//               change on the falling edge; outputs are checked 1 ns later,
//               well away from the rising edge.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam logic [31:0] I_LB  = 32'b100000 << 26;
    localparam logic [31:0] I_LH  = 32'b100001 << 26;
    localparam logic [31:0] I_LW  = 32'b100011 << 26;
    localparam logic [31:0] I_LBU = 32'b100100 << 26;
    localparam logic [31:0] I_SB  = 32'b101000 << 26;
    localparam logic [31:0] I_SH  = 32'b101001 << 26;

    logic        clk;
    logic        rst;
    logic        mem_readM;
    logic        mem_writeM;
    logic [31:0] instrM;
    logic [31:0] aluoutM;
    logic [31:0] rt_valueM;
    logic        excM;
    logic        flushM;
    logic        stall_otherM;
    logic [31:0] mem_rdataM;
    logic        mem_stallM;
    logic        adelM;
    logic        adesM;

    int n_cmp;
    int n_err;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_readM    (mem_readM),
        .mem_writeM   (mem_writeM),
        .instrM       (instrM),
        .aluoutM      (aluoutM),
        .rt_valueM    (rt_valueM),
        .excM         (excM),
        .flushM       (flushM),
        .stall_otherM (stall_otherM),
        .dbus         (bus),
        .mem_rdataM   (mem_rdataM),
        .mem_stallM   (mem_stallM),
        .adelM        (adelM),
        .adesM        (adesM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: rising edge, then falling edge where inputs change.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_readM         = 1'b0;
        mem_writeM        = 1'b0;
        excM              = 1'b0;
        flushM            = 1'b0;
        stall_otherM      = 1'b0;
        bus.data_addr_ok  = 1'b0;
        bus.data_data_ok  = 1'b0;
        bus.data_rdata    = 32'h0;
    endtask

    // Load with immediate addr_ok and data_ok in the following cycle.
    task automatic do_load(input string tag, input logic [31:0] instr,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp);
        mem_readM = 1'b1; instrM = instr; aluoutM = addr;
        #1;
        chk({tag, "_idle_stall"}, mem_stallM, 1);
        chk({tag, "_idle_req"}, bus.data_req, 0);
        step();
        bus.data_addr_ok = 1'b1;
        #1;
        chk({tag, "_req"}, bus.data_req, 1);
        chk({tag, "_req_stall"}, mem_stallM, 1);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
        #1;
        chk({tag, "_wait_req"}, bus.data_req, 0);
        chk({tag, "_rdata"}, mem_rdataM, exp);
        chk({tag, "_ok_stall"}, mem_stallM, 0);
        step();
        idle_inputs();
        #1;
        chk({tag, "_after_req"}, bus.data_req, 0);
        chk({tag, "_after_rdata"}, mem_rdataM, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        instrM = 32'h0; aluoutM = 32'h0; rt_valueM = 32'h0;
        idle_inputs();
        #2;
        // Reset state
        chk("rst_req",   bus.data_req,   0);
        chk("rst_wr",    bus.data_wr,    0);
        chk("rst_size",  bus.data_size,  0);
        chk("rst_addr",  bus.data_addr,  0);
        chk("rst_wdata", bus.data_wdata, 0);
        chk("rst_rdata", mem_rdataM,     0);
        chk("rst_stall", mem_stallM,     0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // LW, full-handshake latency and size
        mem_readM = 1'b1; instrM = I_LW; aluoutM = 32'h8000_0004;
        #1;
        chk("lw_idle_stall", mem_stallM, 1);
        chk("lw_idle_req", bus.data_req, 0);
        step();
        bus.data_addr_ok = 1'b1;
        #1;
        chk("lw_req", bus.data_req, 1);
        chk("lw_size", bus.data_size, 2);
        chk("lw_addr", bus.data_addr, 32'h8000_0004);
        chk("lw_wr", bus.data_wr, 0);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
        #1;
        chk("lw_wait_req", bus.data_req, 0);
        chk("lw_rdata", mem_rdataM, 32'h1234_5678);
        chk("lw_ok_stall", mem_stallM, 0);
        step();
        idle_inputs();
        #1;
        chk("lw_after_req", bus.data_req, 0);
        chk("lw_after_stall", mem_stallM, 0);
        step();

        // Byte/half extraction and extension
        do_load("lb",  I_LB,  32'h8000_0003, 32'h80FF_7F01, 32'hFFFF_FF80);
        step();
        do_load("lbu", I_LBU, 32'h8000_0003, 32'h80FF_7F01, 32'h0000_0080);
        step();
        do_load("lh",  I_LH,  32'h8000_0002, 32'h80FF_7F01, 32'hFFFF_80FF);
        step();
        do_load("lb1", I_LB,  32'h8000_0001, 32'h80FF_7F01, 32'h0000_007F);
        step();

        // SB with addr_ok held off for three REQ cycles
        mem_writeM = 1'b1; instrM = I_SB; aluoutM = 32'h8000_0001; rt_valueM = 32'h0000_00A5;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sb_hold_req",   bus.data_req,   1);
            chk("sb_hold_addr",  bus.data_addr,  32'h8000_0001);
            chk("sb_hold_wdata", bus.data_wdata, 32'hA5A5_A5A5);
            chk("sb_hold_stall", mem_stallM,     1);
            // Upstream changes must not disturb the held request.
            aluoutM = 32'h1111_1110; rt_valueM = 32'h0000_003C;
            step();
        end
        bus.data_addr_ok = 1'b1;
        #1;
        chk("sb_req",   bus.data_req,   1);
        chk("sb_wr",    bus.data_wr,    1);
        chk("sb_size",  bus.data_size,  0);
        chk("sb_wdata", bus.data_wdata, 32'hA5A5_A5A5);
        chk("sb_addr",  bus.data_addr,  32'h8000_0001);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        #1;
        chk("sb_ok_stall", mem_stallM, 0);
        step();
        idle_inputs();
        step();

        // Alignment exceptions
        mem_readM = 1'b1; instrM = I_LW; aluoutM = 32'h8000_0002;
        #1;
        chk("adel", adelM, 1);
        chk("adel_ades", adesM, 0);
        chk("adel_stall", mem_stallM, 0);
        step();
        #1;
        chk("adel_noreq", bus.data_req, 0);
        idle_inputs();
        mem_writeM = 1'b1; instrM = I_SH; aluoutM = 32'h8000_0001;
        #1;
        chk("ades", adesM, 1);
        chk("ades_adel", adelM, 0);
        chk("ades_stall", mem_stallM, 0);
        step();
        #1;
        chk("ades_noreq", bus.data_req, 0);
        idle_inputs();
        step();

        // Flush while waiting: response drained and ignored
        mem_readM = 1'b1; instrM = I_LW; aluoutM = 32'h8000_0010;
        step();
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; flushM = 1'b1;
        #1;
        chk("fl_wait_stall", mem_stallM, 1);
        step();
        flushM = 1'b0; mem_readM = 1'b0;
        #1;
        chk("fl_discard_stall", mem_stallM, 1);
        step();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("fl_ok_stall", mem_stallM, 1);
        chk("fl_ok_rdata", mem_rdataM, 0);
        step();
        idle_inputs();
        #1;
        chk("fl_after_stall", mem_stallM, 0);
        chk("fl_after_req", bus.data_req, 0);
        step();
        #1;
        chk("fl_after_req2", bus.data_req, 0);
        step();

        // Response while another stall holds the instruction in M
        mem_readM = 1'b1; instrM = I_LW; aluoutM = 32'h8000_0008;
        step();
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hCAFE_F00D; stall_otherM = 1'b1;
        #1;
        chk("hd_ok_rdata", mem_rdataM, 32'hCAFE_F00D);
        chk("hd_ok_stall", mem_stallM, 0);
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hd_rdata", mem_rdataM, 32'hCAFE_F00D);
            chk("hd_req",   bus.data_req, 0);
            chk("hd_stall", mem_stallM, 0);
            step();
        end
        stall_otherM = 1'b0;
        #1;
        chk("hd_release_rdata", mem_rdataM, 32'hCAFE_F00D);
        step();
        mem_readM = 1'b0;
        #1;
        chk("hd_idle_rdata", mem_rdataM, 0);
        chk("hd_idle_req", bus.data_req, 0);
        step();

        // Asynchronous reset in the middle of a request
        mem_readM = 1'b1; instrM = I_LW; aluoutM = 32'h8000_0020;
        step();
        #1;
        chk("ar_req", bus.data_req, 1);
        rst = 1'b0;
        #1;
        chk("ar_req_cleared", bus.data_req, 0);
        chk("ar_addr_cleared", bus.data_addr, 0);
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        #1;
        chk("ar_idle_req", bus.data_req, 0);
        chk("ar_idle_stall", mem_stallM, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
